// File: rtl/exec_pkg.sv
// Shared constants for the EX stage: ALU control codes, ALUOp classes and the
// effective-operation decode used by instruction_execution.
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  // Internal-only codes: PASSB has no funct encoding, so a raw 1111 is remapped to ZERO.
  localparam logic [3:0] ALU_ZERO  = 4'b1110;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  function automatic logic [3:0] effectiveCode(input logic memAccess,
                                               input logic [1:0] aluOp,
                                               input logic [3:0] aluControl);
    logic [3:0] code;
    code = ALU_ZERO;
    if (memAccess) begin
      code = ALU_ADD;
    end else begin
      case (aluOp)
        ALUOP_ADD:   code = ALU_ADD;
        ALUOP_SUB:   code = ALU_SUB;
        ALUOP_FUNCT: code = (aluControl == ALU_PASSB) ? ALU_ZERO : aluControl;
        default:     code = ALU_PASSB;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU driven by an effective operation code.
// Shift operations exist only when INSTR_EXEC_SHIFT_EN is defined.
module alu
  import exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  code,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (code)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_XOR:   result = a ^ b;
      ALU_SUB:   result = a - b;
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_LUI:   result = {b[15:0], 16'd0};
      ALU_NOR:   result = ~(a | b);
      ALU_PASSB: result = b;
`ifdef INSTR_EXEC_SHIFT_EN
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
`endif
      default:   result = 32'd0;
    endcase
  end

endmodule

// File: rtl/instruction_execution.sv
// MIPS EX stage: operand/destination muxing, ALU op override, EX/MEM register.
// Optional shifter controlled by the INSTR_EXEC_SHIFT_EN macro (see alu).
module instruction_execution
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        regWriteE,
  input  logic        memToRegE,
  input  logic        memWriteE,
  input  logic [3:0]  ALUControlE,
  input  logic [1:0]  ALUOpE,
  input  logic        ALUSrcE,
  input  logic        regDstE,
  input  logic [31:0] signImmE,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  output logic [4:0]  writeRegE,
  output logic [31:0] AluOutE,
  input  logic [31:0] value1,
  input  logic [31:0] value2
);

  logic [31:0] srcB;
  logic [4:0]  dest;
  logic [3:0]  aluCode;
  logic [31:0] aluResult;
  // RsE travels with the stage for hazard detection only.
  logic        unusedRs;

  assign unusedRs = ^RsE;
  assign srcB     = ALUSrcE ? signImmE : value2;
  assign dest     = regDstE ? RdE : RtE;
  assign aluCode  = effectiveCode(memToRegE | memWriteE, ALUOpE, ALUControlE);

  alu u_alu (
    .a      (value1),
    .b      (srcB),
    .code   (aluCode),
    .result (aluResult)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      AluOutE   <= 32'd0;
      writeRegE <= 5'd0;
    end else begin
      AluOutE   <= aluResult;
      writeRegE <= regWriteE ? dest : 5'd0;
    end
  end

endmodule

// File: tb/tb_instruction_execution.sv
// Self-checking bench for instruction_execution: directed cases plus random
// stimulus compared against a behavioural reference model.
module tb_instruction_execution;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ALUOpE;
  logic [31:0] signImmE, value1, value2;
  logic [4:0]  RsE, RtE, RdE;
  logic [4:0]  writeRegE;
  logic [31:0] AluOutE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_execution dut (
    .clk(clk), .reset(reset), .regWriteE(regWriteE), .memToRegE(memToRegE),
    .memWriteE(memWriteE), .ALUControlE(ALUControlE), .ALUOpE(ALUOpE),
    .ALUSrcE(ALUSrcE), .regDstE(regDstE), .signImmE(signImmE), .RsE(RsE),
    .RtE(RtE), .RdE(RdE), .writeRegE(writeRegE), .AluOutE(AluOutE),
    .value1(value1), .value2(value2)
  );

  // Reference model straight from the operation table.
  function automatic logic [31:0] refResult();
    logic [31:0] a, b;
    int unsigned s;
    a = value1;
    b = ALUSrcE ? signImmE : value2;
    s = int'(b % 32);
    if (reset) return 32'd0;
    if (memToRegE || memWriteE) return a + b;
    if (ALUOpE == 2'd0) return a + b;
    if (ALUOpE == 2'd1) return a - b;
    if (ALUOpE == 2'd3) return b;
    case (ALUControlE)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd6:  return a - b;
      4'd7:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b * 32'd65536;
      4'd12: return 32'hFFFF_FFFF - (a | b);
`ifdef INSTR_EXEC_SHIFT_EN
      4'd4:  return a << s;
      4'd5:  return a >> s;
      4'd8:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] refDest();
    if (reset || !regWriteE) return 5'd0;
    return regDstE ? RdE : RtE;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Clock one edge and compare both outputs against the model.
  task automatic step(input string tag);
    logic [31:0] expOut;
    logic [4:0]  expReg;
    expOut = refResult();
    expReg = refDest();
    @(posedge clk);
    #1;
    checkVal({tag, ".AluOutE"}, AluOutE, expOut);
    checkVal({tag, ".writeRegE"}, {27'd0, writeRegE}, {27'd0, expReg});
    $display("%s: op=%0d ctrl=%h a=%h b=%h -> out=%h wr=%0d", tag, ALUOpE, ALUControlE,
             value1, ALUSrcE ? signImmE : value2, AluOutE, writeRegE);
  endtask

  initial begin
    reset = 1'b1; regWriteE = 1'b1; memToRegE = 1'b0; memWriteE = 1'b0;
    ALUControlE = 4'hF; ALUOpE = 2'b01; ALUSrcE = 1'b0; regDstE = 1'b1;
    signImmE = 32'd0; RsE = 5'd7; RtE = 5'd1; RdE = 5'd3;
    value1 = 32'd10; value2 = 32'd12;
    @(posedge clk); #1;
    checkVal("reset.AluOutE", AluOutE, 32'd0);
    checkVal("reset.writeRegE", {27'd0, writeRegE}, 32'd0);

    reset = 1'b0;
    step("sub");
    checkVal("sub.const", AluOutE, 32'hFFFF_FFFE);
    checkVal("sub.dest", {27'd0, writeRegE}, 32'd3);

    // Inputs changing between edges must not disturb the outputs.
    value1 = 32'd999; #3;
    checkVal("hold.AluOutE", AluOutE, 32'hFFFF_FFFE);
    value1 = 32'd10;

    ALUSrcE = 1'b1; signImmE = 32'd100; ALUOpE = 2'b00;
    step("addi");
    checkVal("addi.const", AluOutE, 32'd110);
    regDstE = 1'b0;
    step("rt_dest");
    checkVal("rt_dest.const", {27'd0, writeRegE}, 32'd1);

    ALUSrcE = 1'b0; ALUOpE = 2'b10; value1 = -32'sd5; value2 = 32'd3;
    ALUControlE = 4'b0111; step("slt");
    checkVal("slt.const", AluOutE, 32'd1);
    ALUControlE = 4'b1001; step("sltu");
    checkVal("sltu.const", AluOutE, 32'd0);
    ALUControlE = 4'b1100; step("nor");
    checkVal("nor.const", AluOutE, ~(32'hFFFF_FFFB | 32'd3));
    ALUControlE = 4'b1111; step("funct_1111");
    checkVal("funct_1111.const", AluOutE, 32'd0);

    memWriteE = 1'b1; ALUOpE = 2'b01; value1 = 32'h1000; signImmE = 32'd8;
    ALUSrcE = 1'b1; regWriteE = 1'b0;
    step("store_addr");
    checkVal("store_addr.const", AluOutE, 32'h1008);
    checkVal("store_addr.dest", {27'd0, writeRegE}, 32'd0);

    memWriteE = 1'b0; regWriteE = 1'b1; reset = 1'b1;
    step("mid_reset");
    reset = 1'b0; ALUOpE = 2'b00; ALUSrcE = 1'b0;
    value1 = 32'hFFFF_FFFF; value2 = 32'd1;
    step("wrap");
    checkVal("wrap.const", AluOutE, 32'd0);

    ALUOpE = 2'b10; ALUControlE = 4'b1000; value1 = 32'h8000_0000; value2 = 32'd4;
    step("sra");
`ifdef INSTR_EXEC_SHIFT_EN
    checkVal("sra.const", AluOutE, 32'hF800_0000);
`else
    checkVal("sra.const", AluOutE, 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      reset       = ($urandom_range(0, 19) == 0);
      regWriteE   = 1'($urandom);
      memToRegE   = ($urandom_range(0, 7) == 0);
      memWriteE   = ($urandom_range(0, 7) == 0);
      ALUControlE = 4'($urandom);
      ALUOpE      = 2'($urandom);
      ALUSrcE     = 1'($urandom);
      regDstE     = 1'($urandom);
      signImmE    = $urandom;
      value1      = $urandom;
      value2      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      RsE         = 5'($urandom);
      RtE         = 5'($urandom);
      RdE         = 5'($urandom);
      step($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
